down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter: N, default 7, count MSB index; count width is N+1 bits, declared [0:N].
REQ-002 clock  input  1  sole clock; all state updates on the falling edge.
REQ-003 clear_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  load strobe; captures load_val into count and reload register.
REQ-005 load_val  input  N+1  value to load.
REQ-006 start  input  1  begin or resume counting.
REQ-007 stop  input  1  pause counting.
REQ-008 reload_en  input  1  auto-reload at terminal count when high.
REQ-009 count  output  N+1  current count value, registered.
REQ-010 busy  output  1  high while state is RUN, registered.
REQ-011 zero  output  1  high when count == 0, combinational from count.
REQ-012 done  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-013 The block SHALL implement states IDLE, RUN, HOLD; all transitions occur on the falling edge of clock.
REQ-014 Priority per edge SHALL be: clear_n low > load > stop > start > count.
REQ-015 load high, any state: count <= load_val, reload_reg <= load_val, state -> IDLE, done <= 0.
REQ-016 IDLE/HOLD, start high, stop low, count != 0: state -> RUN; count does not change on that edge.
REQ-017 IDLE/HOLD, start high, count == 0: start ignored, state unchanged.
REQ-018 RUN, stop high: state -> HOLD, count frozen, done <= 0; stop in IDLE/HOLD has no effect.
REQ-019 RUN, count > 1: count <= count - 1 each edge, done <= 0.
REQ-020 RUN, count == 1, reload_en low: count <= 0, done <= 1, state -> IDLE.
REQ-021 RUN, count == 1, reload_en high, reload_reg != 0: count <= reload_reg, done <= 1, remain RUN; done period equals reload_reg cycles.
REQ-022 RUN, count == 1, reload_en high, reload_reg == 0: behave as REQ-020.
REQ-023 reload_en SHALL be sampled only at the count == 1 edge; toggling it at other times has no effect.
REQ-024 done SHALL be high for exactly one cycle per terminal event and low in all other cycles.
REQ-025 Count arithmetic SHALL be unsigned N+1 bits; count SHALL never wrap below 0 (no 0 -> all-ones transition).
REQ-026 start and stop together SHALL resolve to stop (RUN -> HOLD; IDLE/HOLD unchanged).
REQ-027 load together with start SHALL load and go to IDLE; start is ignored that edge.

Reset
REQ-028 clear_n low at a falling edge SHALL force count = 0, reload_reg = 0, state = IDLE, busy = 0, done = 0, zero = 1, overriding all other inputs.
REQ-029 Reset mid-RUN SHALL abort immediately with no done pulse; block remains IDLE until load/start after clear_n returns high.

Verification
REQ-030 Reset, load 5, start, hold inputs low -> count 5,4,3,2,1,0 on successive edges; done high exactly in the 0 cycle; busy falls same edge; zero = 1 after.
REQ-031 load 3, reload_en = 1, start -> count 3,2,1,3,2,1,...; done pulses every 3 cycles; busy stays 1.
REQ-032 load 10, start, stop after 4 decrements -> count holds 6 with busy 0; start -> resumes 5,4,...; start+stop same edge while RUN -> HOLD.
REQ-033 load 0 then start -> stays IDLE, count 0, zero 1, no done; load 255 (N=7), run to terminal -> no wrap, done once.
REQ-034 load 8, start, clear_n low at count 4 -> count 0, IDLE, done 0 that edge and after.
REQ-035 During RUN at count 2, pulse load with 9 -> count 9, IDLE, busy 0, no done.

Source files
------------

// File: rtl/down_counter_if.sv
// Control/status bundle for down_counter.
// Host drives load/start/stop strobes; counter returns count and flags.
interface down_counter_if #(
  parameter int N = 7
);
  logic       load;
  logic [0:N] load_val;
  logic       start;
  logic       stop;
  logic       reload_en;
  logic [0:N] count;
  logic       busy;
  logic       zero;
  logic       done;

  modport master (
    output load, load_val, start, stop, reload_en,
    input  count, busy, zero, done
  );

  modport slave (
    input  load, load_val, start, stop, reload_en,
    output count, busy, zero, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with run/hold control and optional auto-reload.
// All state advances on the falling edge of clock.
module down_counter #(
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         clear_n,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [0:N] ONE = (N+1)'(1);

  state_e     state_q, state_d;
  logic [0:N] count_q, count_d;
  logic [0:N] reload_q, reload_d;
  logic       done_q, done_d;
  logic       busy_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.stop) begin
            state_d = HOLD;
          end else if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            done_d = 1'b1;
            // reload_en only matters on the terminal edge
            if (bus.reload_en && reload_q != '0) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        IDLE, HOLD: begin
          if (bus.start && !bus.stop && count_q != '0)
            state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= (state_d == RUN);
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Randomized and directed bench for down_counter.
// A behavioural model tracks count, mode and done in plain integers.
module tb_down_counter;

  localparam int N = 7;

  logic clock;
  logic clear_n;
  int   checks;
  int   errors;

  // model: mode 0 idle, 1 counting, 2 paused
  int m_cnt, m_rel, m_mode, m_done;

  down_counter_if #(.N(N)) bus ();

  down_counter #(.N(N)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.load      = 1'b0;
    bus.load_val  = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.reload_en = 1'b0;
    clear_n       = 1'b1;
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!clear_n) begin
      m_cnt = 0; m_rel = 0; m_mode = 0;
    end else if (bus.load) begin
      m_cnt = int'(bus.load_val);
      m_rel = m_cnt;
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (bus.stop) m_mode = 2;
      else if (m_cnt == 1) begin
        m_done = 1;
        if (bus.reload_en && m_rel != 0) m_cnt = m_rel;
        else begin m_cnt = 0; m_mode = 0; end
      end else m_cnt = m_cnt - 1;
    end else if (bus.start && !bus.stop && m_cnt != 0) begin
      m_mode = 1;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
  endtask

  task automatic load_and_start(input int v);
    bus.load = 1'b1; bus.load_val = 8'(v);
    step();
    bus.load = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.load = 1'b1; bus.load_val = 8'd77; bus.start = 1'b1;
    clear_n = 1'b0;
    step();
    checks++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset: count=%0d busy=%b done=%b zero=%b want 0/0/0/1",
               bus.count, bus.busy, bus.done, bus.zero);
    end
    idle_inputs();
  endtask

  task automatic test_countdown();
    int exp;
    do_reset();
    load_and_start(5);
    checks++;
    if (bus.count !== 8'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_edge: count=%0d busy=%b want 5/1",
               bus.count, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      exp = 4 - i;
      checks++;
      if (bus.count !== 8'(exp) || bus.done !== (exp == 0) ||
          bus.busy !== (exp != 0) || bus.zero !== (exp == 0)) begin
        errors++;
        $display("FAIL countdown[%0d]: count=%0d done=%b busy=%b zero=%b want %0d",
                 i, bus.count, bus.done, bus.busy, bus.zero, exp);
      end
    end
    step();
    checks++;
    if (bus.count !== 8'd0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL countdown_after: count=%0d done=%b want 0/0",
               bus.count, bus.done);
    end
  endtask

  task automatic test_reload();
    int exp;
    do_reset();
    bus.reload_en = 1'b1;
    load_and_start(3);
    for (int i = 0; i < 9; i++) begin
      step();
      exp = 3 - ((i + 1) % 3);
      checks++;
      if (bus.count !== 8'(exp) || bus.done !== (exp == 3) ||
          bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL reload[%0d]: count=%0d done=%b busy=%b want %0d",
                 i, bus.count, bus.done, bus.busy, exp);
      end
    end
    bus.reload_en = 1'b0;
  endtask

  task automatic test_stop_resume();
    do_reset();
    load_and_start(10);
    repeat (4) step();
    bus.stop = 1'b1;
    step();
    step();
    checks++;
    if (bus.count !== 8'd6 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold: count=%0d busy=%b want 6/0", bus.count, bus.busy);
    end
    bus.stop = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++;
    if (bus.count !== 8'd4 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL resume: count=%0d busy=%b want 4/1", bus.count, bus.busy);
    end
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    step();
    checks++;
    if (bus.count !== 8'd4 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop: count=%0d busy=%b want 4/0",
               bus.count, bus.busy);
    end
    idle_inputs();
  endtask

  task automatic test_zero_and_max();
    int dones;
    do_reset();
    load_and_start(0);
    step();
    checks++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 ||
        bus.zero !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: count=%0d busy=%b zero=%b done=%b",
               bus.count, bus.busy, bus.zero, bus.done);
    end
    load_and_start(255);
    dones = 0;
    for (int i = 0; i < 258; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.count !== 8'((i < 255) ? 254 - i : 0)) begin
        errors++;
        $display("FAIL max_run[%0d]: count=%0d", i, bus.count);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL max_done: pulses=%0d want 1", dones);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    load_and_start(8);
    repeat (4) step();
    checks++;
    if (bus.count !== 8'd4) begin
      errors++;
      $display("FAIL pre_clear: count=%0d want 4", bus.count);
    end
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL clear_mid[%0d]: count=%0d busy=%b done=%b",
                 i, bus.count, bus.busy, bus.done);
      end
      step();
    end
  endtask

  task automatic test_load_midrun();
    do_reset();
    load_and_start(5);
    repeat (3) step();
    bus.load = 1'b1; bus.load_val = 8'd9;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.count !== 8'd9 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL load_mid[%0d]: count=%0d busy=%b done=%b want 9/0/0",
                 i, bus.count, bus.busy, bus.done);
      end
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    m_cnt = 0; m_rel = 0; m_mode = 0; m_done = 0;
    for (int i = 0; i < 600; i++) begin
      clear_n       = ($urandom_range(0, 99) != 0);
      bus.load      = ($urandom_range(0, 15) == 0);
      bus.load_val  = ($urandom_range(0, 7) == 0) ?
                      8'($urandom) : 8'($urandom_range(0, 6));
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.stop      = ($urandom_range(0, 9) == 0);
      bus.reload_en = $urandom_range(0, 1) == 1;
      model_edge();
      step();
      checks++;
      if (bus.count !== 8'(m_cnt) || bus.busy !== (m_mode == 1) ||
          bus.done !== (m_done == 1) || bus.zero !== (m_cnt == 0)) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d busy=%b done=%b zero=%b want %0d/%0d/%0d",
                 i, bus.count, bus.busy, bus.done, bus.zero,
                 m_cnt, m_mode == 1, m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    @(posedge clock);
    test_reset();
    test_countdown();
    test_reload();
    test_stop_resume();
    test_zero_and_max();
    test_reset_midrun();
    test_load_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
